// File: rtl/scalu_rs_pkg.sv
// Shared definitions for the scalar-ALU reservation station.
// Holds the default depth, the micro-op field widths, the slot record and a
// small helper that decides whether a pending operand matches a broadcast.
package scalu_rs_pkg;

    localparam int RS_ENTRIES_DEFAULT = 8;

    localparam int OP_W    = 5;
    localparam int ROBID_W = 7;
    localparam int RD_W    = 6;
    localparam int XLEN    = 32;

    // One station slot. When an operand is not ready its value field holds
    // the producer robid in the low ROBID_W bits.
    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic               op1_rdy;
        logic [XLEN-1:0]    op1;
        logic               op2_rdy;
        logic [XLEN-1:0]    op2;
    } rs_slot_t;

    // True when a still-pending operand is waiting on the robid being broadcast.
    function automatic logic tag_hit(input logic               rdy,
                                     input logic [XLEN-1:0]    val,
                                     input logic               wb_v,
                                     input logic [ROBID_W-1:0] wb_id);
        return ~rdy & wb_v & (val[ROBID_W-1:0] == wb_id);
    endfunction

endpackage

// File: rtl/scalu_rs_pick.sv
// Lowest-index priority picker.
// Ports:
//   i_req   - request vector, bit 0 has highest priority
//   o_grant - one-hot grant of the lowest set request bit (0 if none)
//   o_idx   - binary index of the granted bit (0 if none)
//   o_any   - at least one request bit is set
module scalu_rs_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IW'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scalu_rs.sv
// Reservation station in front of the single-cycle scalar ALU.
// Accepts dispatched micro-ops with possibly pending operands, wakes them up
// from the writeback broadcast bus and issues the lowest-index ready slot.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   dispatch_*                    - incoming micro-op; rs_stall back-pressures it
//   wb_valid/wb_robid/wb_result   - writeback broadcast used for wakeup
//   exers_scalu_issue, exers_*    - issue valid and data to the ALU
//   scalu_stall                   - ALU back-pressure; issue completes when low
//   rob_flush                     - discard every entry and any same-cycle dispatch
// Issue handshake: exers_scalu_issue is a valid signal and ~scalu_stall is the
// ready; the slot is retired on the edge where both are true, and while the
// ALU stalls the outputs keep presenting the lowest-index ready slot.
module scalu_rs
    import scalu_rs_pkg::*;
#(
    parameter int RS_ENTRIES = RS_ENTRIES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dispatch_valid,
    input  logic [OP_W-1:0]    dispatch_op,
    input  logic [ROBID_W-1:0] dispatch_robid,
    input  logic [RD_W-1:0]    dispatch_rd,
    input  logic               dispatch_op1_rdy,
    input  logic [XLEN-1:0]    dispatch_op1,
    input  logic               dispatch_op2_rdy,
    input  logic [XLEN-1:0]    dispatch_op2,
    output logic               rs_stall,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [XLEN-1:0]    wb_result,
    output logic               exers_scalu_issue,
    output logic [OP_W-1:0]    exers_scalu_op,
    output logic [ROBID_W-1:0] exers_robid,
    output logic [RD_W-1:0]    exers_rd,
    output logic [XLEN-1:0]    exers_op1,
    output logic [XLEN-1:0]    exers_op2,
    input  logic               scalu_stall,
    input  logic               rob_flush
);

    localparam int IW = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    rs_slot_t r_slots [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] w_free_vec;
    logic [RS_ENTRIES-1:0] w_ready_vec;
    logic [RS_ENTRIES-1:0] w_free_grant;
    logic [RS_ENTRIES-1:0] w_iss_grant;
    logic [IW-1:0]         w_free_idx;
    logic [IW-1:0]         w_iss_idx;
    logic                  w_free_any;
    logic                  w_iss_any;
    logic                  w_alloc;
    logic                  w_fire;
    logic                  w_unused_free_idx;
    rs_slot_t              w_new_slot;
    rs_slot_t              w_sel_slot;

    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_free_vec[i]  = ~r_slots[i].valid;
            w_ready_vec[i] = r_slots[i].valid & r_slots[i].op1_rdy & r_slots[i].op2_rdy;
        end
    end

    scalu_rs_pick #(.N(RS_ENTRIES), .IW(IW)) u_alloc_pick (
        .i_req   (w_free_vec),
        .o_grant (w_free_grant),
        .o_idx   (w_free_idx),
        .o_any   (w_free_any)
    );

    scalu_rs_pick #(.N(RS_ENTRIES), .IW(IW)) u_issue_pick (
        .i_req   (w_ready_vec),
        .o_grant (w_iss_grant),
        .o_idx   (w_iss_idx),
        .o_any   (w_iss_any)
    );

    // Allocation only needs the one-hot grant; the index is not used.
    assign w_unused_free_idx = ^w_free_idx;

    // Full is judged on registered state only, so a slot issued this cycle
    // frees capacity one cycle later.
    assign rs_stall = ~w_free_any;
    assign w_alloc  = dispatch_valid & ~rs_stall & ~rob_flush;
    assign w_fire   = w_iss_any & ~scalu_stall;

    // New entry, with same-cycle writeback bypass for pending operands.
    always_comb begin
        w_new_slot         = '0;
        w_new_slot.valid   = 1'b1;
        w_new_slot.op      = dispatch_op;
        w_new_slot.robid   = dispatch_robid;
        w_new_slot.rd      = dispatch_rd;
        w_new_slot.op1_rdy = dispatch_op1_rdy;
        w_new_slot.op1     = dispatch_op1;
        w_new_slot.op2_rdy = dispatch_op2_rdy;
        w_new_slot.op2     = dispatch_op2;
        if (tag_hit(dispatch_op1_rdy, dispatch_op1, wb_valid, wb_robid)) begin
            w_new_slot.op1_rdy = 1'b1;
            w_new_slot.op1     = wb_result;
        end
        if (tag_hit(dispatch_op2_rdy, dispatch_op2, wb_valid, wb_robid)) begin
            w_new_slot.op2_rdy = 1'b1;
            w_new_slot.op2     = wb_result;
        end
    end

    // Issue data come straight from registered slot state; zero when idle.
    always_comb begin
        w_sel_slot = '0;
        if (w_iss_any) begin
            w_sel_slot = r_slots[w_iss_idx];
        end
    end

    assign exers_scalu_issue = w_iss_any;
    assign exers_scalu_op    = w_sel_slot.op;
    assign exers_robid       = w_sel_slot.robid;
    assign exers_rd          = w_sel_slot.rd;
    assign exers_op1         = w_sel_slot.op1;
    assign exers_op2         = w_sel_slot.op2;

    // Allocation targets a free slot and issue a valid one, so the two
    // branches below never act on the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (rob_flush) begin
                    r_slots[i].valid <= 1'b0;
                end else if (w_alloc && w_free_grant[i]) begin
                    r_slots[i] <= w_new_slot;
                end else if (r_slots[i].valid) begin
                    if (w_fire && w_iss_grant[i]) begin
                        r_slots[i].valid <= 1'b0;
                    end
                    if (tag_hit(r_slots[i].op1_rdy, r_slots[i].op1, wb_valid, wb_robid)) begin
                        r_slots[i].op1_rdy <= 1'b1;
                        r_slots[i].op1     <= wb_result;
                    end
                    if (tag_hit(r_slots[i].op2_rdy, r_slots[i].op2, wb_valid, wb_robid)) begin
                        r_slots[i].op2_rdy <= 1'b1;
                        r_slots[i].op2     <= wb_result;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scalu_rs.sv
module tb_scalu_rs;

  localparam int N     = 8;
  localparam int ISS_W = 5 + 7 + 6 + 32 + 32;

  logic        clk;
  logic        rst;
  logic        dispatch_valid;
  logic [4:0]  dispatch_op;
  logic [6:0]  dispatch_robid;
  logic [5:0]  dispatch_rd;
  logic        dispatch_op1_rdy;
  logic [31:0] dispatch_op1;
  logic        dispatch_op2_rdy;
  logic [31:0] dispatch_op2;
  logic        rs_stall;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_scalu_issue;
  logic [4:0]  exers_scalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        scalu_stall;
  logic        rob_flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ISS_W-1:0] exp_q[$];

  scalu_rs #(.RS_ENTRIES(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_valid    (dispatch_valid),
    .dispatch_op       (dispatch_op),
    .dispatch_robid    (dispatch_robid),
    .dispatch_rd       (dispatch_rd),
    .dispatch_op1_rdy  (dispatch_op1_rdy),
    .dispatch_op1      (dispatch_op1),
    .dispatch_op2_rdy  (dispatch_op2_rdy),
    .dispatch_op2      (dispatch_op2),
    .rs_stall          (rs_stall),
    .wb_valid          (wb_valid),
    .wb_robid          (wb_robid),
    .wb_result         (wb_result),
    .exers_scalu_issue (exers_scalu_issue),
    .exers_scalu_op    (exers_scalu_op),
    .exers_robid       (exers_robid),
    .exers_rd          (exers_rd),
    .exers_op1         (exers_op1),
    .exers_op2         (exers_op2),
    .scalu_stall       (scalu_stall),
    .rob_flush         (rob_flush)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The station as a bag of numbered entries: oldest-free slot gets new work,
  // the smallest-numbered ready entry is offered to the ALU.
  typedef struct {
    bit          valid;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    bit          r1;
    logic [31:0] v1;
    bit          r2;
    logic [31:0] v2;
  } m_entry_t;

  m_entry_t m[N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m[i].valid = 0;
      m[i].r1    = 0;
      m[i].r2    = 0;
    end
  endtask

  always @(negedge clk) begin
    m_entry_t nx[N];
    int sel;
    int cnt;
    int fr;
    if (rst) begin
      model_clear();
      exp_q.delete();
    end else begin
      sel = -1;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (m[i].valid) cnt++;
        if (sel < 0 && m[i].valid && m[i].r1 && m[i].r2) sel = i;
      end
      check("rs_stall", rs_stall, cnt == N);
      check("issue_valid", exers_scalu_issue, sel >= 0);
      if (sel >= 0)
        exp_q.push_back({m[sel].op, m[sel].robid, m[sel].rd, m[sel].v1, m[sel].v2});
      else
        check("idle_data", {exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2}, '0);

      nx = m;
      if (rob_flush) begin
        for (int i = 0; i < N; i++) nx[i].valid = 0;
      end else begin
        if (sel >= 0 && !scalu_stall) nx[sel].valid = 0;
        if (wb_valid) begin
          for (int i = 0; i < N; i++) begin
            if (m[i].valid && !m[i].r1 && m[i].v1[6:0] == wb_robid) begin
              nx[i].r1 = 1; nx[i].v1 = wb_result;
            end
            if (m[i].valid && !m[i].r2 && m[i].v2[6:0] == wb_robid) begin
              nx[i].r2 = 1; nx[i].v2 = wb_result;
            end
          end
        end
        if (dispatch_valid && cnt < N) begin
          fr = -1;
          for (int i = 0; i < N; i++) if (fr < 0 && !m[i].valid) fr = i;
          nx[fr].valid = 1;
          nx[fr].op    = dispatch_op;
          nx[fr].robid = dispatch_robid;
          nx[fr].rd    = dispatch_rd;
          nx[fr].r1    = dispatch_op1_rdy;
          nx[fr].v1    = dispatch_op1;
          nx[fr].r2    = dispatch_op2_rdy;
          nx[fr].v2    = dispatch_op2;
          if (!dispatch_op1_rdy && wb_valid && dispatch_op1[6:0] == wb_robid) begin
            nx[fr].r1 = 1; nx[fr].v1 = wb_result;
          end
          if (!dispatch_op2_rdy && wb_valid && dispatch_op2[6:0] == wb_robid) begin
            nx[fr].r2 = 1; nx[fr].v2 = wb_result;
          end
        end
      end
      m = nx;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [ISS_W-1:0] got;
    logic [ISS_W-1:0] exp;
    #1;
    if (!rst && exers_scalu_issue) begin
      got = {exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2};
      if (exp_q.size() == 0) begin
        check("issue_unexpected", got, '1);
      end else begin
        exp = exp_q.pop_front();
        check("issue_data", got, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 0;
    wb_valid       = 0;
    rob_flush      = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                      input logic r1, input logic [31:0] v1, input logic r2, input logic [31:0] v2);
    dispatch_valid   = 1;
    dispatch_op      = op;
    dispatch_robid   = robid;
    dispatch_rd      = rd;
    dispatch_op1_rdy = r1;
    dispatch_op1     = v1;
    dispatch_op2_rdy = r2;
    dispatch_op2     = v2;
  endtask

  task automatic disp_tick(input logic [6:0] robid, input logic r1, input logic [31:0] v1,
                           input logic r2, input logic [31:0] v2);
    disp(5'(robid), robid, 6'(robid), r1, v1, r2, v2);
    tick();
    dispatch_valid = 0;
  endtask

  task automatic wb(input logic [6:0] id, input logic [31:0] val);
    wb_valid  = 1;
    wb_robid  = id;
    wb_result = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    idle();
    dispatch_op = 0; dispatch_robid = 0; dispatch_rd = 0;
    dispatch_op1_rdy = 0; dispatch_op1 = 0; dispatch_op2_rdy = 0; dispatch_op2 = 0;
    wb_robid = 0; wb_result = 0; scalu_stall = 0;
    repeat (2) tick();
    check("reset_issue", exers_scalu_issue, 1'b0);
    check("reset_stall", rs_stall, 1'b0);
    check("reset_data", {exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2}, '0);
    rst = 0;
    tick();

    // Reset in the middle of traffic.
    scalu_stall = 1;
    disp_tick(7'd1, 1, 32'd1, 1, 32'd1);
    disp_tick(7'd2, 1, 32'd2, 1, 32'd2);
    disp_tick(7'd3, 1, 32'd3, 1, 32'd3);
    check("pre_reset_issue", exers_scalu_issue, 1'b1);
    rst = 1;
    #1;
    check("async_reset_issue", exers_scalu_issue, 1'b0);
    check("async_reset_stall", rs_stall, 1'b0);
    tick();
    rst = 0;
    scalu_stall = 0;
    tick();
    disp(5'h10, 7'd20, 6'd3, 1, 32'd3, 1, 32'd4);
    tick();
    dispatch_valid = 0;
    check("post_reset_issue", exers_scalu_issue, 1'b1);
    check("post_reset_op1", exers_op1, 32'd3);
    check("post_reset_op2", exers_op2, 32'd4);
    check("post_reset_robid", exers_robid, 7'd20);
    tick();

    // Wakeup from the broadcast bus.
    disp(5'h2, 7'd9, 6'd9, 0, 32'd5, 1, 32'd7);
    tick();
    dispatch_valid = 0;
    check("wake_not_ready", exers_scalu_issue, 1'b0);
    tick();
    wb(7'd5, 32'hAA);
    tick();
    wb_valid = 0;
    check("wake_issue", exers_scalu_issue, 1'b1);
    check("wake_op1", exers_op1, 32'hAA);
    check("wake_op2", exers_op2, 32'd7);
    tick();

    // Same-cycle dispatch bypass.
    disp(5'h3, 7'd11, 6'd11, 1, 32'd2, 0, 32'd12);
    wb(7'd12, 32'd1);
    tick();
    idle();
    check("bypass_issue", exers_scalu_issue, 1'b1);
    check("bypass_op2", exers_op2, 32'd1);
    tick();

    // Fill under back-pressure.
    scalu_stall = 1;
    for (int k = 0; k < N; k++) begin
      disp_tick(7'(30 + k), 1, 32'(k), 1, 32'(k + 100));
      if (k == N - 2) check("almost_full_stall", rs_stall, 1'b0);
    end
    check("full_stall", rs_stall, 1'b1);
    check("full_hold_robid", exers_robid, 7'd30);
    scalu_stall = 0;
    tick();
    scalu_stall = 1;
    check("drain_one_stall", rs_stall, 1'b0);
    check("drain_one_next", exers_robid, 7'd31);
    scalu_stall = 0;
    repeat (N - 1) tick();
    check("drained", exers_scalu_issue, 1'b0);

    // Priority among ready slots.
    scalu_stall = 1;
    disp_tick(7'd50, 0, 32'd40, 1, 32'd0);
    disp_tick(7'd51, 0, 32'd41, 1, 32'd0);
    disp_tick(7'd52, 1, 32'd2, 1, 32'd2);
    disp_tick(7'd53, 1, 32'd3, 0, 32'd41);
    disp_tick(7'd54, 0, 32'd41, 0, 32'd41);
    disp_tick(7'd55, 1, 32'd5, 1, 32'd5);
    scalu_stall = 0;
    #1;
    check("prio_first", exers_robid, 7'd52);
    tick();
    check("prio_second", exers_robid, 7'd55);
    tick();
    check("prio_none", exers_scalu_issue, 1'b0);
    wb(7'd40, 32'h400);
    disp(5'h6, 7'd56, 6'd56, 1, 32'd6, 1, 32'd6);
    tick();
    idle();
    check("prio_woken_low", exers_robid, 7'd50);
    tick();
    check("prio_new_high", exers_robid, 7'd56);
    wb(7'd41, 32'h410);
    tick();
    idle();
    check("prio_multi_wake", exers_robid, 7'd51);
    repeat (3) tick();
    check("prio_drained", exers_scalu_issue, 1'b0);

    // Flush with a dispatch in the same cycle.
    scalu_stall = 1;
    for (int k = 0; k < 4; k++) disp_tick(7'(60 + k), 1, 32'(k), 1, 32'(k));
    rob_flush = 1;
    disp(5'h4, 7'd64, 6'd1, 1, 32'd64, 1, 32'd64);
    tick();
    idle();
    check("flush_issue", exers_scalu_issue, 1'b0);
    check("flush_stall", rs_stall, 1'b0);
    scalu_stall = 0;
    repeat (3) tick();
    check("flush_dropped", exers_scalu_issue, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] v1;
      logic [31:0] v2;
      bit r1;
      bit r2;
      r1 = ($urandom_range(0, 1) == 1);
      r2 = ($urandom_range(0, 1) == 1);
      v1 = $urandom();
      v2 = $urandom();
      if (!r1) v1[6:0] = 7'($urandom_range(0, 15));
      if (!r2) v2[6:0] = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6)
        disp(5'($urandom()), 7'($urandom()), 6'($urandom()), r1, v1, r2, v2);
      else
        dispatch_valid = 0;
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_robid    = 7'($urandom_range(0, 15));
      wb_result   = $urandom();
      scalu_stall = ($urandom_range(0, 9) < 3);
      rob_flush   = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();
    rob_flush = 1;
    tick();
    idle();
    scalu_stall = 0;
    repeat (3) tick();
    check("final_empty", exers_scalu_issue, 1'b0);
    check("final_queue", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
